// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if
//   Bundles the multiplexed display lines being monitored together with the
//   decoder's capture results.
//   master : display side / monitor consumer (drives anode_in, segment_in)
//   slave  : seg_scan_decoder (drives the capture and status outputs)
//   anode_in[3:0]     active-low one-hot digit enables
//   segment_in[6:0]   active-low segments, bit0=a .. bit6=g
//   raw_out[27:0]     captured patterns, slot n at [7n+6:7n]
//   bcd_out[15:0]     decoded digits, slot n at [4n+3:4n]
//   slot_valid_out    per-slot captured-this-frame flags
//   frame_done_out    one-cycle pulse when all four slots are captured
//   decode_err_out    sticky unrecognised-pattern flag
//   stall_out         scan watchdog flag
interface seg_scan_decoder_if;
    logic [3:0]  anode_in;
    logic [6:0]  segment_in;
    logic [27:0] raw_out;
    logic [15:0] bcd_out;
    logic [3:0]  slot_valid_out;
    logic        frame_done_out;
    logic        decode_err_out;
    logic        stall_out;

    modport master (
        output anode_in, segment_in,
        input  raw_out, bcd_out, slot_valid_out, frame_done_out,
               decode_err_out, stall_out
    );

    modport slave (
        input  anode_in, segment_in,
        output raw_out, bcd_out, slot_valid_out, frame_done_out,
               decode_err_out, stall_out
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Samples the time-multiplexed anode/segment lines of a 4-digit seven-segment
//   display, waits for each digit slot to hold steady for SETTLE_CYCLES, then
//   captures the raw pattern and decodes it back to BCD.
// Ports:
//   clk_in  rising-edge clock
//   rst_in  asynchronous active-high reset
//   bus     seg_scan_decoder_if.slave (anode/segment in, capture results out)
// Parameters:
//   SETTLE_CYCLES   cycles anode+segment must hold before capture (1..65535)
//   TIMEOUT_CYCLES  cycles without anode change before stall_out is raised
// Build option:
//   SCAN_TIMEOUT_EN  when defined, adds the anode watchdog driving stall_out;
//                    otherwise stall_out is tied low.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    seg_scan_decoder_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        cap_en;

    // an_q/seg_q: registered inputs; an_p/seg_p: the sample before that.
    logic [3:0]  an_q, an_p, cap_an;
    logic [6:0]  seg_q, seg_p;
    logic [27:0] raw_r;
    logic [15:0] bcd_r;
    logic [3:0]  valid_r;
    logic        fd_r, err_r;

    logic        an_ok, changed;
    logic [1:0]  slot;
    logic [4:0]  dec;   // {err, bcd}

    // Exactly one anode bit low.
    function automatic logic onehot_low(input logic [3:0] a);
        logic [3:0] n;
        n = ~a;
        return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] slot_of(input logic [3:0] a);
        case (a)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [4:0] decode7(input logic [6:0] s);
        case (s)
            7'b1000000: return {1'b0, 4'h0};
            7'b1111001: return {1'b0, 4'h1};
            7'b0100100: return {1'b0, 4'h2};
            7'b0110000: return {1'b0, 4'h3};
            7'b0011001: return {1'b0, 4'h4};
            7'b0010010: return {1'b0, 4'h5};
            7'b0000010: return {1'b0, 4'h6};
            7'b1111000: return {1'b0, 4'h7};
            7'b0000000: return {1'b0, 4'h8};
            7'b0010000: return {1'b0, 4'h9};
            7'b1111111: return {1'b0, 4'hF};
            default:    return {1'b1, 4'hE};
        endcase
    endfunction

    assign an_ok   = onehot_low(an_q);
    assign changed = (an_q != an_p) || (seg_q != seg_p);
    // In CAPTURE the previous sample is the last value that held through
    // SETTLE, so it is the one written even if the lines just moved.
    assign slot    = slot_of(an_p);
    assign dec     = decode7(seg_p);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            an_q  <= 4'hF;
            an_p  <= 4'hF;
            seg_q <= 7'h7F;
            seg_p <= 7'h7F;
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            an_q  <= bus.anode_in;
            seg_q <= bus.segment_in;
            an_p  <= an_q;
            seg_p <= seg_q;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap_en    = 1'b0;
        if (!an_ok) begin
            state_nxt = IDLE;
            cnt_nxt   = 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SETTLE;
                    cnt_nxt   = 16'd0;
                end
                SETTLE: begin
                    if (changed)                 cnt_nxt   = 16'd0;
                    else if (cnt == SETTLE_LAST) state_nxt = CAPTURE;
                    else                         cnt_nxt   = cnt + 16'd1;
                end
                CAPTURE: begin
                    cap_en    = 1'b1;
                    state_nxt = HOLD;
                    cnt_nxt   = 16'd0;
                end
                HOLD: begin
                    // Segment-only changes are ignored; only a new slot re-arms.
                    if (an_q != cap_an) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = 16'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            raw_r   <= '1;
            bcd_r   <= 16'hFFFF;
            valid_r <= 4'd0;
            fd_r    <= 1'b0;
            err_r   <= 1'b0;
            cap_an  <= 4'hF;
        end else begin
            // A full valid set is visible for one cycle, then retires as the
            // frame_done pulse; CAPTURE never directly follows CAPTURE.
            fd_r <= &valid_r;
            if (&valid_r)
                valid_r <= 4'd0;
            else if (cap_en)
                valid_r[slot] <= 1'b1;
            if (cap_en) begin
                raw_r[7*slot +: 7] <= seg_p;
                bcd_r[4*slot +: 4] <= dec[3:0];
                err_r              <= err_r | dec[4];
                cap_an             <= an_p;
            end
        end
    end

    assign bus.raw_out        = raw_r;
    assign bus.bcd_out        = bcd_r;
    assign bus.slot_valid_out = valid_r;
    assign bus.frame_done_out = fd_r;
    assign bus.decode_err_out = err_r;

`ifdef SCAN_TIMEOUT_EN
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

    logic [31:0] wd;
    logic        stall_r;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wd      <= 32'd0;
            stall_r <= 1'b0;
        end else if (an_q != an_p) begin
            wd      <= 32'd0;
            stall_r <= 1'b0;
        end else if (wd != TO_LIM) begin
            wd <= wd + 32'd1;
            if (wd + 32'd1 == TO_LIM) stall_r <= 1'b1;
        end
    end

    assign bus.stall_out = stall_r;
`else
    assign bus.stall_out = 1'b0;
`endif

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart to the 4-digit multiplexed seven-segment driver. Samples the time-multiplexed anode and segment lines and waits for each digit slot to settle. Captures the raw segment pattern per slot and decodes it back to BCD. Used as an on-chip monitor and loopback checker for the display path, and as a self-check in simulation.

Parameters:
SETTLE_CYCLES, 16, consecutive clk_in cycles anode+segment must hold unchanged before capture (1..65535)
TIMEOUT_CYCLES, 1000000, cycles without any anode change before stall is flagged (only with SCAN_TIMEOUT_EN)

Ports:
clk_in  input  1  system clock, rising-edge
rst_in  input  1  reset, asynchronous, active-high
anode_in  input  4  digit enables, active-low one-hot (4'b1110 = slot 0 ... 4'b0111 = slot 3)
segment_in  input  7  segment lines, active-low, bit0=a ... bit6=g
raw_out  output  28  captured patterns, slot n at [7n+6:7n]
bcd_out  output  16  decoded values, slot n at [4n+3:4n]
slot_valid_out  output  4  bit n set once slot n is captured in the current frame
frame_done_out  output  1  one-cycle pulse when all four slots are captured
decode_err_out  output  1  sticky, set on capture of an unrecognised pattern
stall_out  output  1  scan stalled (SCAN_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (async assert, sync release):
  - raw_out = all ones (blank); bcd_out = 16'hFFFF.
  - slot_valid_out, frame_done_out, decode_err_out, stall_out = 0.
  - FSM = IDLE; settle counter = 0.
- Inputs are registered once before use; all latencies below are counted from the registered sample.
- One-hot check: anode valid iff exactly one bit is 0. Any other value (1111, 1100, ...) forces IDLE and clears the settle counter.
- FSM:
  - IDLE -> SETTLE when anode is valid.
  - SETTLE: counter increments while anode and segment equal the previous sample. Any change restarts the counter (still SETTLE if anode is valid, else IDLE).
  - SETTLE -> CAPTURE when the counter reaches SETTLE_CYCLES-1.
  - CAPTURE (one cycle): writes raw slot n, bcd slot n and slot_valid bit n. -> HOLD.
  - HOLD -> SETTLE when the anode changes to another valid value; -> IDLE when it becomes invalid. A segment-only change in HOLD is ignored.
- Capture-to-output latency: outputs update on the clock edge that leaves CAPTURE.
- Decode table (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank 1111111 -> 4'hF, no error.
  - Anything else -> 4'hE and decode_err_out set. decode_err_out clears only on reset.
- Frame: when the capture makes slot_valid all ones, frame_done_out pulses the next cycle. slot_valid_out clears in that same cycle; raw_out and bcd_out hold.
- Recapturing an already-valid slot before the frame completes overwrites its data; the frame is not completed early.
- Reset mid-SETTLE or mid-CAPTURE: no partial write, all outputs return to their reset values.

Optional Feature:
SCAN_TIMEOUT_EN:
- Defined:
  - A 32-bit watchdog counts cycles since the last change of registered anode_in.
  - On reaching TIMEOUT_CYCLES, stall_out = 1 and the counter saturates.
  - The next anode change clears stall_out and the counter.
  - Captures continue normally while stalled.
- Undefined: no watchdog logic; stall_out constant 0.

Test Plan:
1. Reset with SETTLE_CYCLES=4; drive 1110/1000000 held 10 cycles -> bcd_out[3:0]=0, raw_out[6:0]=1000000, slot_valid_out=0001, no frame_done.
2. Cycle slots 0..3 with digits 1,2,3,4, each held 10 cycles -> bcd_out=16'h4321, one frame_done_out pulse, slot_valid_out back to 0000.
3. Slot 2 segment toggles every 3 cycles (SETTLE_CYCLES=4) -> slot 2 never captured, slot_valid_out[2]=0, no frame_done.
4. anode_in=1100 for 20 cycles, then 1111 -> FSM stays IDLE, outputs unchanged.
5. Slot 1 with 1010101 held -> bcd_out[7:4]=E, decode_err_out=1 and stays 1 through later good frames until rst_in.
6. SCAN_TIMEOUT_EN, TIMEOUT_CYCLES=50: anode frozen 60 cycles -> stall_out=1 at cycle 50; anode changes -> stall_out=0 next cycle. Assert rst_in mid-SETTLE -> all outputs at reset values immediately.
